// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// -----------------------------------------------------------------------------
// Parametrised universal shift register. This is a WIDTH-bit edge-triggered
// register bank supporting these operations:
//   - hold
//   - parallel load
//   - logical shift left / right
//   - rotate left / right
//   - Johnson counting
//   - synchronous clear
// A shift counter tracks the number of shift-type operations. A registered
// done pulse marks every WIDTH-th shift-type operation.
//
// Parameters
//   WIDTH      register width in bits (>= 2)
//   CNT_W      shift_cnt width, 2**CNT_W must exceed WIDTH
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   en         operation enable, 0 holds q/shift_cnt and clears done
//   mode       operation select (HOLD, LOAD, SHL, SHR, ROL, ROR, JOHN, CLR)
//   d          parallel load data
//   si_left    serial input entering the MSB on shift right
//   si_right   serial input entering the LSB on shift left
//   q          register contents
//   q_bar      bitwise complement of q
//   so_left    serial output, q MSB
//   so_right   serial output, q LSB
//   shift_cnt  shift-type operations since last load/clear/wrap
//   done       one-cycle pulse after WIDTH shift-type operations
//   parity     (only with SHREG_PARITY_EN) reduction XOR of q
//
// Configuration macro
//   SHREG_PARITY_EN  adds the combinational parity output
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si_left,
    input  logic             si_right,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             so_left,
    output logic             so_right,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
`ifdef SHREG_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_JOHN = 3'b110,
        MODE_CLR  = 3'b111
    } mode_t;

    // The count wraps on the operation that would reach WIDTH.
    // That same operation raises done.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mode_t            op;
    logic [WIDTH-1:0] q_next;
    logic             is_shift;

    assign op = mode_t'(mode);

    // Next register value for the selected mode, and whether this mode
    // counts as a shift-type operation. Modes SHL through JOHN count.
    always_comb begin
        q_next   = q;
        is_shift = 1'b0;
        case (op)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL: begin
                q_next   = {q[WIDTH-2:0], si_right};
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                q_next   = {si_left, q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                q_next   = {q[0], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_JOHN: begin
                q_next   = {~q[0], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_CLR: q_next = '0;
            default:  q_next = q;
        endcase
    end

    // Register bank, shift counter and done pulse.
    // done is high only in the cycle after the wrapping shift operation.
    // Every other cycle, enabled or not, drops it back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= '0;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (en) begin
            q <= q_next;
            if (is_shift) begin
                if (shift_cnt == CNT_LAST) begin
                    shift_cnt <= '0;
                    done      <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt + CNT_W'(1);
                    done      <= 1'b0;
                end
            end else begin
                if (op == MODE_LOAD || op == MODE_CLR) begin
                    shift_cnt <= '0;
                end
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign q_bar    = ~q;
    assign so_left  = q[WIDTH-1];
    assign so_right = q[0];

`ifdef SHREG_PARITY_EN
    assign parity = ^q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// -----------------------------------------------------------------------------
// Directed self-checking bench for univ_shift_reg at WIDTH=8, CNT_W=4.
// Expected values are hand-computed constants or tables.
// Stimulus is applied one clock at a time through applyStimulus.
// Results are compared through checkOutput.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_JOHN = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             si_left;
    logic             si_right;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             so_left;
    logic             so_right;
    logic [CNT_W-1:0] shift_cnt;
    logic             done;
`ifdef SHREG_PARITY_EN
    logic             parity;
`endif

    int check_count;
    int error_count;

    logic [7:0] john_seq [16];

    univ_shift_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .si_left  (si_left),
        .si_right (si_right),
        .q        (q),
        .q_bar    (q_bar),
        .so_left  (so_left),
        .so_right (so_right),
        .shift_cnt(shift_cnt),
        .done     (done)
`ifdef SHREG_PARITY_EN
        ,
        .parity   (parity)
`endif
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one set of inputs, waits for the active edge, then settles 1 unit.
    task automatic applyStimulus(input logic en_v, input logic [2:0] mode_v,
                                 input logic [7:0] d_v, input logic sl_v,
                                 input logic sr_v);
        en       = en_v;
        mode     = mode_v;
        d        = d_v;
        si_left  = sl_v;
        si_right = sr_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        john_seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                     8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

        reset    = 1'b1;
        en       = 1'b0;
        mode     = M_HOLD;
        d        = '0;
        si_left  = 1'b0;
        si_right = 1'b0;

        // Power-on reset values
        #12;
        checkOutput("rst_q",     32'(q),         32'h00);
        checkOutput("rst_qbar",  32'(q_bar),     32'hFF);
        checkOutput("rst_cnt",   32'(shift_cnt), 32'h0);
        checkOutput("rst_done",  32'(done),      32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Build q=A5 with shift_cnt=4 (5A rotated left 4), then async reset mid-cycle
        applyStimulus(1'b1, M_LOAD, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, M_ROL, 8'h00, 1'b0, 1'b0);
        checkOutput("pre_rst_q",   32'(q),         32'hA5);
        checkOutput("pre_rst_cnt", 32'(shift_cnt), 32'h4);
        en = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_q",    32'(q),         32'h00);
        checkOutput("mid_rst_qbar", 32'(q_bar),     32'hFF);
        checkOutput("mid_rst_cnt",  32'(shift_cnt), 32'h0);
        checkOutput("mid_rst_done", 32'(done),      32'h0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // After reset the count restarts: done only on the 8th shift
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, M_ROL, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("post_rst_done%0d", i), 32'(done), (i == 7) ? 32'h1 : 32'h0);
        end

        // LOAD 81 then SHL with si_right=1
        applyStimulus(1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        checkOutput("load81_q",   32'(q),         32'h81);
        checkOutput("load81_sol", 32'(so_left),   32'h1);
        applyStimulus(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
        checkOutput("shl_q",      32'(q),         32'h03);
        checkOutput("shl_sol",    32'(so_left),   32'h0);
        checkOutput("shl_sor",    32'(so_right),  32'h1);
        checkOutput("shl_qbar",   32'(q_bar),     32'hFC);
        checkOutput("shl_cnt",    32'(shift_cnt), 32'h1);

        // HOLD keeps q and count
        applyStimulus(1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1);
        checkOutput("hold_q",   32'(q),         32'h03);
        checkOutput("hold_cnt", 32'(shift_cnt), 32'h1);

        // LOAD 01, ROL x8 returns to 01; done only after 8th op
        applyStimulus(1'b1, M_LOAD, 8'h01, 1'b0, 1'b0);
        checkOutput("load01_cnt", 32'(shift_cnt), 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, M_ROL, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("rol_q%0d", i),    32'(q),    32'(8'h01 << ((i + 1) % 8)));
            checkOutput($sformatf("rol_done%0d", i), 32'(done), (i == 7) ? 32'h1 : 32'h0);
        end
        checkOutput("rol_cnt", 32'(shift_cnt), 32'h0);
        applyStimulus(1'b1, M_HOLD, 8'h00, 1'b0, 1'b0);
        checkOutput("rol_done_clear", 32'(done), 32'h0);

        // CLR then Johnson x16
        applyStimulus(1'b1, M_CLR, 8'h00, 1'b0, 1'b0);
        checkOutput("clr_q", 32'(q), 32'h00);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, M_JOHN, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("john_q%0d", i),    32'(q),    32'(john_seq[i]));
            checkOutput($sformatf("john_done%0d", i), 32'(done), (i == 7 || i == 15) ? 32'h1 : 32'h0);
        end

        // LOAD F0, SHR x3, disabled x4, SHR x5
        applyStimulus(1'b1, M_LOAD, 8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, M_SHR, 8'h00, 1'b0, 1'b0);
        checkOutput("shr3_q",   32'(q),         32'h1E);
        checkOutput("shr3_cnt", 32'(shift_cnt), 32'h3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, M_SHR, 8'h00, 1'b1, 1'b1);
            checkOutput($sformatf("en0_q%0d", i),    32'(q),         32'h1E);
            checkOutput($sformatf("en0_cnt%0d", i),  32'(shift_cnt), 32'h3);
            checkOutput($sformatf("en0_done%0d", i), 32'(done),      32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, M_SHR, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("shr5_done%0d", i), 32'(done), (i == 4) ? 32'h1 : 32'h0);
        end
        checkOutput("shr8_q",   32'(q),         32'h00);
        checkOutput("shr8_cnt", 32'(shift_cnt), 32'h0);

        // Mode change mid-sequence: SHL x3 then ROR x5 still wraps
        applyStimulus(1'b1, M_LOAD, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, M_SHL, 8'h00, 1'b0, 1'b0);
        checkOutput("mix_shl_q", 32'(q), 32'hE0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, M_ROR, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("mix_done%0d", i), 32'(done), (i == 4) ? 32'h1 : 32'h0);
        end
        checkOutput("mix_ror_q", 32'(q), 32'h07);

`ifdef SHREG_PARITY_EN
        // Parity output tracks q combinationally
        applyStimulus(1'b1, M_LOAD, 8'h07, 1'b0, 1'b0);
        checkOutput("par_07", 32'(parity), 32'h1);
        applyStimulus(1'b1, M_SHL, 8'h00, 1'b0, 1'b0);
        checkOutput("par_shl_q", 32'(q),      32'h0E);
        checkOutput("par_0e",    32'(parity), 32'h1);
        applyStimulus(1'b1, M_LOAD, 8'h03, 1'b0, 1'b0);
        checkOutput("par_03",    32'(parity), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
